// File: rtl/alu_arbiter_if.sv
// Bus between the two ALU requesters, the shared ALU and alu_arbiter.
// slave is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int FW    = 4
);
  logic             req0;
  logic             req1;
  logic [FW-1:0]    op0;
  logic [FW-1:0]    op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] res;
  logic             c_out;
  logic             z_out;
  logic             busy;
  logic             gnt;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [FW-1:0]    alu_f;
  logic [WIDTH-1:0] alu_s;
  logic             alu_c;
  logic             alu_z;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_s, alu_c, alu_z,
    output ack0, ack1, res, c_out, z_out, busy, gnt, alu_a, alu_b, alu_f
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_s, alu_c, alu_z,
    input  ack0, ack1, res, c_out, z_out, busy, gnt, alu_a, alu_b, alu_f
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer for the shared combinational ALU: grant, issue
// from registers, capture result and flags, then pulse the winner's ack.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int FW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_arbiter_if.slave  bus,
  output logic [1:0]    dbgState
);

  // Handshake: a requester holds req high until its ack; ack is a one-cycle
  // pulse with res/c_out/z_out valid in that cycle, and req must drop then.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic             last;
  logic             winner;
  logic             anyReq;
  logic             gntReg;
  logic             ack0Reg;
  logic             ack1Reg;
  logic             cReg;
  logic             zReg;
  logic [WIDTH-1:0] resReg;
  logic [WIDTH-1:0] aluAReg;
  logic [WIDTH-1:0] aluBReg;
  logic [FW-1:0]    aluFReg;

  always_comb begin
    stateNext = state;
    anyReq    = bus.req0 | bus.req1;
    // A tie goes to the index that did not win last; a lone requester always wins.
    winner    = (bus.req0 && bus.req1) ? ~last : bus.req1;
    case (state)
      IDLE:    if (anyReq) stateNext = ISSUE;
      ISSUE:   stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      gntReg  <= 1'b0;
      ack0Reg <= 1'b0;
      ack1Reg <= 1'b0;
      resReg  <= '0;
      cReg    <= 1'b0;
      zReg    <= 1'b0;
      aluAReg <= '0;
      aluBReg <= '0;
      aluFReg <= '0;
    end else begin
      state   <= stateNext;
      ack0Reg <= 1'b0;
      ack1Reg <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            gntReg  <= winner;
            last    <= winner;
            aluFReg <= winner ? bus.op1 : bus.op0;
            aluAReg <= winner ? bus.a1  : bus.a0;
            aluBReg <= winner ? bus.b1  : bus.b0;
          end
        end
        ISSUE: begin
          // The ALU has had the whole ISSUE cycle to settle from aluA/B/F.
          resReg  <= bus.alu_s;
          cReg    <= bus.alu_c;
          zReg    <= bus.alu_z;
          ack0Reg <= ~gntReg;
          ack1Reg <= gntReg;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack0  = ack0Reg;
  assign bus.ack1  = ack1Reg;
  assign bus.res   = resReg;
  assign bus.c_out = cReg;
  assign bus.z_out = zReg;
  assign bus.busy  = (state != IDLE);
  assign bus.gnt   = gntReg;
  assign bus.alu_a = aluAReg;
  assign bus.alu_b = aluBReg;
  assign bus.alu_f = aluFReg;
  assign dbgState  = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (round-robin pointer and an ALU function).
module tb_alu_arbiter;
  localparam int WIDTH = 4;
  localparam int FW    = 4;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbgState;
  int         checks;
  int         errors;
  int         modelLast;

  alu_arbiter_if #(.WIDTH(WIDTH), .FW(FW)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .FW(FW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // Reference ALU: {carry, zero, result}. Undefined codes give 5 with carry set.
  function automatic logic [5:0] refAlu(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    int   sum;
    logic [3:0] s;
    logic c;
    case (op)
      4'd0: begin s = a; c = 1'b0; end
      4'd1: begin sum = int'(a) - int'(b); s = 4'((sum + 16) % 16); c = (a < b); end
      4'd2: begin s = b; c = 1'b0; end
      4'd3: begin sum = int'(a) + int'(b); s = 4'(sum % 16); c = (sum > 15); end
      4'd4: begin s = ~(a & b); c = 1'b0; end
      default: begin s = 4'b0101; c = 1'b1; end
    endcase
    return {c, (s == 4'd0), s};
  endfunction

  // Stand-in for the shared ALU instance.
  always_comb {bus.alu_c, bus.alu_z, bus.alu_s} = refAlu(bus.alu_f, bus.alu_a, bus.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = '0; bus.op1 = '0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
  endtask

  task automatic wait_ack(output int cycles, output logic g0, output logic g1);
    cycles = 0; g0 = 1'b0; g1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cycles++;
      if (bus.ack0 || bus.ack1) begin
        g0 = bus.ack0; g1 = bus.ack1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    clear_inputs();
    reset_n = 1'b0;
    tick(); tick();
    obs = {bus.ack0, bus.ack1, bus.busy, bus.gnt, bus.c_out, bus.z_out,
           bus.res, bus.alu_a, bus.alu_b, bus.alu_f};
    checks++;
    if (obs !== 22'd0 || dbgState !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h state %0d want 0 state 0", obs, dbgState);
    end
    reset_n = 1'b1;
    modelLast = 1;
  endtask

  task automatic test_add();
    int cyc; logic g0, g1;
    bus.req0 = 1'b1; bus.op0 = 4'b0011; bus.a0 = 4'h9; bus.b0 = 4'h8;
    wait_ack(cyc, g0, g1);
    checks++;
    if (cyc != 2 || {g0, g1} !== 2'b10) begin
      errors++; $display("FAIL add_ack: got cycles %0d acks %b%b want 2 10", cyc, g0, g1);
    end
    checks++;
    if ({bus.c_out, bus.z_out, bus.res} !== 6'b10_0001) begin
      errors++; $display("FAIL add_res: got c%b z%b %h want c1 z0 1", bus.c_out, bus.z_out, bus.res);
    end
    checks++;
    if ({bus.alu_f, bus.alu_a, bus.alu_b} !== 12'h398) begin
      errors++; $display("FAIL add_alu_drive: got %h want 398", {bus.alu_f, bus.alu_a, bus.alu_b});
    end
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.ack1 !== 1'b0) begin
      errors++; $display("FAIL add_idle: got busy %b ack1 %b want 0 0", bus.busy, bus.ack1);
    end
    modelLast = 0;
  endtask

  task automatic test_tie_round_robin();
    int cyc; logic g0, g1;
    test_reset();
    bus.req0 = 1'b1; bus.op0 = 4'b0000; bus.a0 = 4'h3; bus.b0 = 4'h0;
    bus.req1 = 1'b1; bus.op1 = 4'b0010; bus.a1 = 4'h0; bus.b1 = 4'hA;
    wait_ack(cyc, g0, g1);
    checks++;
    if (cyc != 2 || {g0, g1} !== 2'b10 || bus.res !== 4'h3) begin
      errors++; $display("FAIL tie_first: got cycles %0d acks %b%b res %h want 2 10 3", cyc, g0, g1, bus.res);
    end
    bus.req0 = 1'b0;
    wait_ack(cyc, g0, g1);
    checks++;
    if (cyc != 3 || {g0, g1} !== 2'b01 || bus.res !== 4'hA || bus.gnt !== 1'b1) begin
      errors++; $display("FAIL tie_second: got cycles %0d acks %b%b res %h gnt %b want 3 01 a 1", cyc, g0, g1, bus.res, bus.gnt);
    end
    wait_ack(cyc, g0, g1);
    checks++;
    if (cyc != 3 || {g0, g1} !== 2'b01 || bus.res !== 4'hA) begin
      errors++; $display("FAIL single_regrant: got cycles %0d acks %b%b res %h want 3 01 a", cyc, g0, g1, bus.res);
    end
    bus.req1 = 1'b0;
    tick();
    modelLast = 1;
  endtask

  task automatic test_sub();
    int cyc; logic g0, g1;
    bus.req0 = 1'b1; bus.op0 = 4'b0001; bus.a0 = 4'h5; bus.b0 = 4'h5;
    wait_ack(cyc, g0, g1);
    checks++;
    if ({g0, g1} !== 2'b10 || {bus.c_out, bus.z_out, bus.res} !== 6'b01_0000) begin
      errors++; $display("FAIL sub_zero: got acks %b%b c%b z%b %h want 10 c0 z1 0", g0, g1, bus.c_out, bus.z_out, bus.res);
    end
    bus.req0 = 1'b0;
    tick();
    bus.req1 = 1'b1; bus.op1 = 4'b0001; bus.a1 = 4'h2; bus.b1 = 4'h3;
    wait_ack(cyc, g0, g1);
    checks++;
    if ({g0, g1} !== 2'b01 || {bus.c_out, bus.z_out, bus.res} !== 6'b10_1111) begin
      errors++; $display("FAIL sub_borrow: got acks %b%b c%b z%b %h want 01 c1 z0 f", g0, g1, bus.c_out, bus.z_out, bus.res);
    end
    bus.req1 = 1'b0;
    tick();
    modelLast = 1;
  endtask

  task automatic test_ignore_changes();
    int cyc; logic g0, g1;
    bus.req0 = 1'b1; bus.op0 = 4'b0011; bus.a0 = 4'h3; bus.b0 = 4'h4;
    tick();
    bus.req0 = 1'b0; bus.op0 = 4'b0100; bus.a0 = 4'hF; bus.b0 = 4'hF;
    wait_ack(cyc, g0, g1);
    checks++;
    if (cyc != 1 || {g0, g1} !== 2'b10 || bus.res !== 4'h7) begin
      errors++; $display("FAIL ignore_changes: got cycles %0d acks %b%b res %h want 1 10 7", cyc, g0, g1, bus.res);
    end
    tick();
    checks++;
    if ({bus.alu_f, bus.alu_a, bus.alu_b} !== 12'h334 || bus.res !== 4'h7 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL hold_values: got drive %h res %h busy %b want 334 7 0", {bus.alu_f, bus.alu_a, bus.alu_b}, bus.res, bus.busy);
    end
    modelLast = 0;
  endtask

  task automatic test_reset_mid();
    int cyc; logic g0, g1;
    logic [21:0] obs;
    bus.req0 = 1'b1; bus.op0 = 4'b0010; bus.b0 = 4'h6;
    bus.req1 = 1'b1; bus.op1 = 4'b0010; bus.b1 = 4'h9;
    tick();
    checks++;
    if (bus.gnt !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL tie_after_req0: got gnt %b busy %b want 1 1", bus.gnt, bus.busy);
    end
    reset_n = 1'b0;
    tick();
    obs = {bus.ack0, bus.ack1, bus.busy, bus.gnt, bus.c_out, bus.z_out,
           bus.res, bus.alu_a, bus.alu_b, bus.alu_f};
    checks++;
    if (obs !== 22'd0 || dbgState !== 2'd0) begin
      errors++; $display("FAIL reset_mid: got %h state %0d want 0 state 0", obs, dbgState);
    end
    reset_n = 1'b1;
    modelLast = 1;
    wait_ack(cyc, g0, g1);
    checks++;
    if (cyc != 2 || {g0, g1} !== 2'b10 || bus.res !== 4'h6) begin
      errors++; $display("FAIL post_reset_tie: got cycles %0d acks %b%b res %h want 2 10 6", cyc, g0, g1, bus.res);
    end
    clear_inputs();
    tick();
    modelLast = 0;
  endtask

  task automatic test_undefined_nand();
    int cyc; logic g0, g1;
    bus.req1 = 1'b1; bus.op1 = 4'b0111; bus.a1 = 4'($urandom_range(0, 15)); bus.b1 = 4'h2;
    wait_ack(cyc, g0, g1);
    checks++;
    if ({g0, g1} !== 2'b01 || {bus.c_out, bus.z_out, bus.res} !== 6'b10_0101) begin
      errors++; $display("FAIL undefined_op: got acks %b%b c%b z%b %h want 01 c1 z0 5", g0, g1, bus.c_out, bus.z_out, bus.res);
    end
    bus.req1 = 1'b0;
    tick();
    bus.req0 = 1'b1; bus.op0 = 4'b0100; bus.a0 = 4'hF; bus.b0 = 4'hF;
    wait_ack(cyc, g0, g1);
    checks++;
    if ({g0, g1} !== 2'b10 || {bus.c_out, bus.z_out, bus.res} !== 6'b01_0000) begin
      errors++; $display("FAIL nand_zero: got acks %b%b c%b z%b %h want 10 c0 z1 0", g0, g1, bus.c_out, bus.z_out, bus.res);
    end
    bus.req0 = 1'b0;
    tick();
    modelLast = 0;
  endtask

  task automatic test_random();
    int cyc; logic g0, g1;
    int pick, win;
    logic [3:0] op[2], a[2], b[2];
    logic [5:0] expv;
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(1, 3);
      for (int k = 0; k < 2; k++) begin
        op[k] = 4'($urandom_range(0, 15));
        a[k]  = 4'($urandom_range(0, 15));
        b[k]  = 4'($urandom_range(0, 15));
      end
      bus.req0 = pick[0]; bus.req1 = pick[1];
      bus.op0 = op[0]; bus.a0 = a[0]; bus.b0 = b[0];
      bus.op1 = op[1]; bus.a1 = a[1]; bus.b1 = b[1];
      win  = (pick == 3) ? 1 - modelLast : (pick == 2 ? 1 : 0);
      expv = refAlu(op[win], a[win], b[win]);
      wait_ack(cyc, g0, g1);
      checks++;
      if (cyc != 2 || g0 !== (win == 0) || g1 !== (win == 1) || bus.gnt !== 1'(win) ||
          {bus.c_out, bus.z_out, bus.res} !== expv) begin
        errors++;
        $display("FAIL random_op%0d: got cycles %0d acks %b%b gnt %b czr %b want 2 winner %0d czr %b",
                 n, cyc, g0, g1, bus.gnt, {bus.c_out, bus.z_out, bus.res}, win, expv);
      end
      modelLast = win;
      clear_inputs();
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
        errors++; $display("FAIL random_idle%0d: got busy %b acks %b%b want 0 00", n, bus.busy, bus.ack0, bus.ack1);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelLast = 1;
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_add();
    test_tie_round_robin();
    test_sub();
    test_ignore_changes();
    test_reset_mid();
    test_undefined_nand();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the processor's shared 4-bit ALU. Two requesters (instruction path and address/auxiliary path) present an opcode and operands; the block grants one of them round-robin, drives the combinational ALU from registers, captures result and flags, and returns them with a one-cycle acknowledge. It sits between the requesters and the ALU instance. It is the only driver of the ALU inputs.

## Interface
Parameters:
- WIDTH, 4: operand/result width; must match the ALU.
- FW, 4: ALU function-select width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0, req1  in  1  request; held high until the matching ack.
- op0, op1  in  FW  ALU function code per requester.
- a0, b0, a1, b1  in  WIDTH  operands per requester.
- ack0, ack1  out  1  one-cycle pulse; response bus valid in that cycle.
- res  out  WIDTH  registered ALU result.
- c_out, z_out  out  1  registered carry and zero flags.
- busy  out  1  high in every state except IDLE.
- gnt  out  1  index of the current or most recent grantee.
- alu_a, alu_b  out  WIDTH  registered ALU operand drive.
- alu_f  out  FW  registered ALU function drive.
- alu_s  in  WIDTH  ALU result.
- alu_c, alu_z  in  1  ALU carry and zero.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE -> ISSUE when req0 or req1 is high.
  - On that edge, latch the winner's op/a/b into alu_f/alu_a/alu_b and set gnt.
- Tie-break: round-robin pointer `last`.
  - If both request, grant the index not equal to `last`.
  - `last` <= granted index on every grant.
  - A single requester always wins regardless of `last`.
- ISSUE -> RESP unconditionally.
  - On that edge, res <= alu_s, c_out <= alu_c, z_out <= alu_z.
  - ack[gnt] <= 1.
- RESP -> IDLE unconditionally; ack cleared on that edge.
- Requests are sampled only in IDLE. Changes to req/op/a/b during ISSUE or RESP are ignored.
- The requester must drop req in the cycle ack is high. A req still high when the block is back in IDLE is a new request.
- A req withdrawn after grant does not cancel the operation; the ack is still issued.
- Opcodes are passed through unvalidated.
  - Codes outside the ALU's defined set return whatever the ALU produces.
  - For the current ALU, that is res=4'b0101, c_out=1, z_out=0.
- res, c_out and z_out hold their value until the next capture.
- alu_* outputs hold the last issued operation until the next grant.
- Reset values (reset_n low at an edge):
  - state=IDLE, last=1 (so req0 wins the first tie).
  - gnt=0, ack0=ack1=0, busy=0.
  - res=0, c_out=0, z_out=0.
  - alu_a=0, alu_b=0, alu_f=0.
- Reset mid-operation aborts the operation with no ack. The first grant after reset follows the reset pointer.

## Timing
- Cycle 0: IDLE, req high. Edge: grant and operand latch.
- Cycle 1: ISSUE; ALU settles combinationally from registered inputs. Edge: capture.
- Cycle 2: RESP; ack high, res/c_out/z_out valid. Edge: return to IDLE.
- Cycle 3: earliest next grant.
- Latency from request to ack: 2 cycles. Throughput: one operation per 3 cycles.
- The ALU has one full cycle of combinational time (register -> ALU -> register).
- ack0 and ack1 are never high in the same cycle.
- busy is low only in IDLE.

## Test plan
- Reset, then req0 with op=4'b0011, a0=4'h9, b0=4'h8 -> ack0 two cycles after the request; res=4'h1, c_out=1, z_out=0; ack1 stays 0.
- req0 and req1 high together after reset (op0=4'b0000 with a0=4'h3; op1=4'b0010 with b1=4'hA).
  - req1 held high after its ack, req0 dropped after its ack.
  - Expected: ack0 first with res=4'h3, then ack1 with res=4'hA, three cycles apart.
  - Then req1 alone is granted again, since a single requester wins.
- Subtract to zero: op=4'b0001, a=b=4'h5 -> res=0, z_out=1, c_out=0.
  - Subtract borrow: a=4'h2, b=4'h3 -> res=4'hF, c_out=1, z_out=0.
- Operands and op change during ISSUE, and req0 drops during ISSUE -> res reflects the values latched at grant; ack0 still pulses.
- reset_n low during ISSUE -> no ack; all outputs at reset values next cycle; with both requesting, the next tie goes to req0.
- Undefined opcode op=4'b0111 -> res=4'b0101, c_out=1, z_out=0.
  - Then NAND: op=4'b0100, a=b=4'hF -> res=0, z_out=1, c_out=0.
